// File: rtl/time_set_pkg.sv
// Shared types, field indices and BCD limits for the time-set entry front end,
// plus the per-field digit validity check used by the edit FSM.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_HH,
    ST_EDIT_HL,
    ST_EDIT_MH,
    ST_EDIT_ML,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_HH = 2'd0;
  localparam logic [1:0] FIELD_HL = 2'd1;
  localparam logic [1:0] FIELD_MH = 2'd2;
  localparam logic [1:0] FIELD_ML = 2'd3;

  localparam logic [3:0] HH_MAX_24  = 4'd2;
  localparam logic [3:0] HH_MAX_12  = 4'd1;
  localparam logic [3:0] HL_MAX_AT2 = 4'd3;
  localparam logic [3:0] HL_MAX_AT1 = 4'd2;
  localparam logic [3:0] HL_MIN_AT0 = 4'd1;
  localparam logic [3:0] MH_MAX     = 4'd5;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

  // Hour-low limits depend on the already-staged hour-high digit.
  function automatic logic digitValid(input logic [1:0] field,
                                      input logic [3:0] digit,
                                      input logic [3:0] stagedHh,
                                      input logic       hour24);
    logic ok;
    ok = 1'b0;
    if (digit <= DIGIT_MAX) begin
      case (field)
        FIELD_HH: ok = hour24 ? (digit <= HH_MAX_24) : (digit <= HH_MAX_12);
        FIELD_HL: begin
          if (hour24)
            ok = (stagedHh == HH_MAX_24) ? (digit <= HL_MAX_AT2) : 1'b1;
          else if (stagedHh == 4'd0)
            ok = (digit >= HL_MIN_AT0);
          else
            ok = (digit <= HL_MAX_AT1);
        end
        FIELD_MH: ok = (digit <= MH_MAX);
        default:  ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse on each accepted 1-to-0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stableDly;
  logic [CW-1:0] r_count;
  logic          r_press;

  // The count only runs while the synchronized level disagrees with the
  // accepted level and stops at CNT_LAST, so it can never wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_stable    <= 1'b1;
      r_stableDly <= 1'b1;
      r_count     <= '0;
      r_press     <= 1'b0;
    end else begin
      r_sync1     <= key_n_i;
      r_sync2     <= r_sync1;
      r_stableDly <= r_stable;
      r_press     <= r_stableDly & ~r_stable;
      if (r_sync2 != r_stable) begin
        if (r_count == CNT_LAST) begin
          r_stable <= r_sync2;
          r_count  <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign press_o = r_press;

endmodule

// File: rtl/time_set_entry.sv
// Operator time entry: debounced edit/cancel keys walk four BCD fields,
// validate each digit, then commit the whole time with a one-cycle load strobe.
module time_set_entry
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit HOUR24          = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_edit_n_i,
  input  logic       key_cancel_n_i,
  input  logic [3:0] sw_digit_i,
  output logic [3:0] hourhigh_o,
  output logic [3:0] hourlow_o,
  output logic [3:0] minhigh_o,
  output logic [3:0] minlow_o,
  output logic       load_o,
  output logic       editing_o,
  output logic [1:0] field_o,
  output logic       err_o
);

  localparam logic [3:0] RST_HH = HOUR24 ? 4'd0 : 4'd1;
  localparam logic [3:0] RST_HL = HOUR24 ? 4'd0 : 4'd2;

  logic       w_editPress;
  logic       w_cancelPress;
  logic [1:0] w_curField;
  state_t     w_advState;
  logic       w_digitOk;

  state_t     r_state;
  logic [3:0] r_staged [4];
  logic [3:0] r_commit [4];
  logic       r_load;
  logic       r_err;
  logic       r_editing;
  logic [1:0] r_field;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_editDebounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .key_n_i (key_edit_n_i),
    .press_o (w_editPress)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancelDebounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .key_n_i (key_cancel_n_i),
    .press_o (w_cancelPress)
  );

  always_comb begin
    w_curField = FIELD_HH;
    w_advState = ST_COMMIT;
    case (r_state)
      ST_EDIT_HH: begin w_curField = FIELD_HH; w_advState = ST_EDIT_HL; end
      ST_EDIT_HL: begin w_curField = FIELD_HL; w_advState = ST_EDIT_MH; end
      ST_EDIT_MH: begin w_curField = FIELD_MH; w_advState = ST_EDIT_ML; end
      ST_EDIT_ML: begin w_curField = FIELD_ML; w_advState = ST_COMMIT;  end
      default:    begin w_curField = FIELD_HH; w_advState = ST_COMMIT;  end
    endcase
  end

  assign w_digitOk = digitValid(w_curField, sw_digit_i, r_staged[FIELD_HH], HOUR24);

  // editing/field are written alongside every state change so they track
  // the state register exactly; committed digits only move in COMMIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_staged  <= '{RST_HH, RST_HL, 4'd0, 4'd0};
      r_commit  <= '{RST_HH, RST_HL, 4'd0, 4'd0};
      r_load    <= 1'b0;
      r_err     <= 1'b0;
      r_editing <= 1'b0;
      r_field   <= FIELD_HH;
    end else begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_staged <= r_commit;
          if (w_editPress) begin
            r_state   <= ST_EDIT_HH;
            r_editing <= 1'b1;
            r_field   <= FIELD_HH;
          end
        end
        ST_EDIT_HH, ST_EDIT_HL, ST_EDIT_MH, ST_EDIT_ML: begin
          if (w_cancelPress) begin
            r_state   <= ST_IDLE;
            r_editing <= 1'b0;
            r_field   <= FIELD_HH;
          end else if (w_editPress) begin
            if (w_digitOk) begin
              r_staged[w_curField] <= sw_digit_i;
              r_state              <= w_advState;
              if (w_advState == ST_COMMIT) begin
                r_editing <= 1'b0;
                r_field   <= FIELD_HH;
              end else begin
                r_field <= w_curField + 2'd1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_commit <= r_staged;
          r_load   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_editing <= 1'b0;
          r_field   <= FIELD_HH;
        end
      endcase
    end
  end

  assign hourhigh_o = r_commit[FIELD_HH];
  assign hourlow_o  = r_commit[FIELD_HL];
  assign minhigh_o  = r_commit[FIELD_MH];
  assign minlow_o   = r_commit[FIELD_ML];
  assign load_o     = r_load;
  assign err_o      = r_err;
  assign editing_o  = r_editing;
  assign field_o    = r_field;

endmodule

// File: tb/tb_time_set_entry.sv
// Bench for time_set_entry: a 24h and a 12h instance share the keys/switches
// and are compared every cycle against a behavioural model of the entry rules.
module tb_time_set_entry;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       keyEdit = 1'b1;
  logic       keyCancel = 1'b1;
  logic [3:0] sw = 4'd0;

  logic [1:0][3:0] aHh, aHl, aMh, aMl;
  logic [1:0][1:0] aField;
  logic [1:0]      aLoad, aEd, aErr;

  always #5 clk = ~clk;

  time_set_entry #(.DEBOUNCE_CYCLES(N), .HOUR24(1'b1)) dut24 (
    .clk_i(clk), .rst_i(rst), .key_edit_n_i(keyEdit), .key_cancel_n_i(keyCancel),
    .sw_digit_i(sw), .hourhigh_o(aHh[0]), .hourlow_o(aHl[0]), .minhigh_o(aMh[0]),
    .minlow_o(aMl[0]), .load_o(aLoad[0]), .editing_o(aEd[0]), .field_o(aField[0]),
    .err_o(aErr[0]));

  time_set_entry #(.DEBOUNCE_CYCLES(N), .HOUR24(1'b0)) dut12 (
    .clk_i(clk), .rst_i(rst), .key_edit_n_i(keyEdit), .key_cancel_n_i(keyCancel),
    .sw_digit_i(sw), .hourhigh_o(aHh[1]), .hourlow_o(aHl[1]), .minhigh_o(aMh[1]),
    .minlow_o(aMl[1]), .load_o(aLoad[1]), .editing_o(aEd[1]), .field_o(aField[1]),
    .err_o(aErr[1]));

  // Model state: instance 0 is 24h, instance 1 is 12h; key 0 edit, key 1 cancel.
  int mStaged [2][4];
  int mCommit [2][4];
  int mField [2];
  bit mEditing [2];
  bit mPending [2];
  bit mLoad [2];
  bit mErr [2];
  bit hist [2][N+2];
  bit mDeb [2];
  bit mFell [2];
  bit mPress [2];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int loadCnt [2] = '{0, 0};
  int errCnt [2] = '{0, 0};
  int pressCnt = 0;

  // Validity expressed as whole-number hour/minute ranges.
  function automatic bit digitOk(int inst, int fld, int d, int hh);
    if (d > 9) return 1'b0;
    case (fld)
      0: return (inst == 0) ? (d * 10 <= 23) : (d * 10 <= 12);
      1: return (inst == 0) ? (hh * 10 + d <= 23)
                            : (hh * 10 + d >= 1 && hh * 10 + d <= 12);
      2: return d * 10 <= 59;
      default: return 1'b1;
    endcase
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mCommit[i][0] = (i == 0) ? 0 : 1;
      mCommit[i][1] = (i == 0) ? 0 : 2;
      mCommit[i][2] = 0;
      mCommit[i][3] = 0;
      mStaged[i] = mCommit[i];
      mField[i] = 0; mEditing[i] = 0; mPending[i] = 0; mLoad[i] = 0; mErr[i] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < N + 2; j++) hist[k][j] = 1'b1;
      mDeb[k] = 1'b1; mFell[k] = 1'b0; mPress[k] = 1'b0;
    end
  endtask

  task automatic modelFsm(int inst);
    mLoad[inst] = 0;
    mErr[inst] = 0;
    if (mPending[inst]) begin
      mCommit[inst] = mStaged[inst];
      mLoad[inst] = 1;
      mPending[inst] = 0;
    end else if (!mEditing[inst]) begin
      mStaged[inst] = mCommit[inst];
      if (mPress[0]) begin mEditing[inst] = 1; mField[inst] = 0; end
    end else if (mPress[1]) begin
      mEditing[inst] = 0; mField[inst] = 0;
    end else if (mPress[0]) begin
      if (digitOk(inst, mField[inst], int'(sw), mStaged[inst][0])) begin
        mStaged[inst][mField[inst]] = int'(sw);
        if (mField[inst] == 3) begin
          mEditing[inst] = 0; mField[inst] = 0; mPending[inst] = 1;
        end else begin
          mField[inst]++;
        end
      end else begin
        mErr[inst] = 1;
      end
    end
  endtask

  // A key level is accepted after N equal samples seen through two sync stages.
  task automatic modelKeys();
    bit allLow, allHigh;
    for (int k = 0; k < 2; k++) begin
      mPress[k] = mFell[k];
      for (int j = N + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = (k == 0) ? keyEdit : keyCancel;
      allLow = 1'b1; allHigh = 1'b1;
      for (int j = 2; j <= N + 1; j++) begin
        if (hist[k][j]) allLow = 1'b0; else allHigh = 1'b0;
      end
      mFell[k] = mDeb[k] && allLow;
      if (mDeb[k] && allLow) mDeb[k] = 1'b0;
      else if (!mDeb[k] && allHigh) mDeb[k] = 1'b1;
    end
  endtask

  task automatic compareInst(int inst);
    int expField;
    expField = mEditing[inst] ? mField[inst] : 0;
    checks++;
    if (aHh[inst] !== 4'(mCommit[inst][0]) || aHl[inst] !== 4'(mCommit[inst][1]) ||
        aMh[inst] !== 4'(mCommit[inst][2]) || aMl[inst] !== 4'(mCommit[inst][3]) ||
        aLoad[inst] !== mLoad[inst] || aErr[inst] !== mErr[inst] ||
        aEd[inst] !== mEditing[inst] || aField[inst] !== 2'(expField)) begin
      errors++;
      $display("[TB] FAIL cycleCompare inst=%0d cycle=%0d got t=%0h%0h:%0h%0h ld=%0b er=%0b ed=%0b f=%0d want t=%0d%0d:%0d%0d ld=%0b er=%0b ed=%0b f=%0d",
               inst, cycle, aHh[inst], aHl[inst], aMh[inst], aMl[inst], aLoad[inst],
               aErr[inst], aEd[inst], aField[inst], mCommit[inst][0], mCommit[inst][1],
               mCommit[inst][2], mCommit[inst][3], mLoad[inst], mErr[inst],
               mEditing[inst], expField);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    if (rst) begin
      resetModel();
    end else begin
      modelFsm(0);
      modelFsm(1);
      modelKeys();
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      loadCnt[i] += int'(aLoad[i]);
      errCnt[i] += int'(aErr[i]);
      compareInst(i);
    end
    pressCnt += int'(dut24.u_editDebounce.press_o);
  endtask

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(int digit, bit useEdit, bit useCancel);
    sw = 4'(digit);
    keyEdit = ~useEdit;
    keyCancel = ~useCancel;
    repeat (12) step();
    keyEdit = 1'b1;
    keyCancel = 1'b1;
    repeat (12) step();
  endtask

  task automatic checkTime(string name, int inst, int t);
    checkOutput(name, int'(aHh[inst]) * 1000 + int'(aHl[inst]) * 100 +
                      int'(aMh[inst]) * 10 + int'(aMl[inst]), t);
  endtask

  initial begin
    int loads0, errs0;
    $display("[TB] time_set_entry bench, DEBOUNCE_CYCLES=%0d", N);
    resetModel();
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    checkTime("reset24", 0, 0);
    checkTime("reset12", 1, 1200);
    checkOutput("resetEditing", int'(aEd[0]), 0);
    checkOutput("resetNoLoad", loadCnt[0] + loadCnt[1], 0);

    // Clean press latency, then hold for 100 cycles.
    keyEdit = 1'b0;
    pressCnt = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 6) checkOutput("pressEarly", int'(dut24.u_editDebounce.press_o), 0);
      if (i == 7) checkOutput("pressAt7", int'(dut24.u_editDebounce.press_o), 1);
    end
    step();
    checkOutput("enterEdit", int'(aEd[0]), 1);
    repeat (92) step();
    keyEdit = 1'b1;
    repeat (12) step();
    checkOutput("heldOnePulse", pressCnt, 1);
    checkOutput("heldField", int'(aField[0]), 0);

    applyStimulus(2, 1, 0);
    checkOutput("field1", int'(aField[0]), 1);
    applyStimulus(3, 1, 0);
    checkOutput("field2", int'(aField[0]), 2);
    applyStimulus(5, 1, 0);
    checkOutput("field3", int'(aField[0]), 3);
    applyStimulus(9, 1, 0);
    checkOutput("load2359Once", loadCnt[0], 1);
    checkTime("commit2359", 0, 2359);

    // Bounced press: two 3-cycle glitches, then a stable low.
    repeat (2) begin
      keyEdit = 1'b0; repeat (3) step();
      keyEdit = 1'b1; repeat (3) step();
    end
    keyEdit = 1'b0;
    pressCnt = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 6) checkOutput("bounceEarly", pressCnt, 0);
      if (i == 7) checkOutput("bounceAt7", pressCnt, 1);
    end
    repeat (5) step();
    keyEdit = 1'b1;
    repeat (12) step();

    applyStimulus(1, 1, 0);
    applyStimulus(2, 1, 0);
    applyStimulus(0, 0, 1);
    checkOutput("cancelIdle", int'(aEd[0]), 0);
    checkOutput("cancelNoLoad", loadCnt[0], 1);
    checkTime("cancelKeeps", 0, 2359);

    // Invalid digits.
    errs0 = errCnt[0];
    applyStimulus(0, 1, 0);
    applyStimulus(3, 1, 0);
    checkOutput("hh3Field", int'(aField[0]), 0);
    applyStimulus(2, 1, 0);
    applyStimulus(4, 1, 0);
    checkOutput("hl4Field", int'(aField[0]), 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(9, 1, 0);
    applyStimulus(6, 1, 0);
    checkOutput("mh6Field", int'(aField[0]), 2);
    applyStimulus(12, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("invalidErrCount", errCnt[0] - errs0, 4);
    checkTime("commit1900", 0, 1900);

    // Simultaneous cancel and edit in the last field.
    loads0 = loadCnt[0];
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("inML", int'(aField[0]), 3);
    applyStimulus(5, 1, 1);
    checkOutput("bothNoLoad", loadCnt[0] - loads0, 0);
    checkOutput("bothIdle", int'(aEd[0]), 0);
    checkTime("bothKeeps", 0, 1900);

    // Reset in the middle of an edit.
    loads0 = loadCnt[0];
    applyStimulus(0, 1, 0);
    applyStimulus(2, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("inMH", int'(aField[0]), 2);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    checkTime("midReset24", 0, 0);
    checkTime("midReset12", 1, 1200);
    checkOutput("midResetNoLoad", loadCnt[0] - loads0, 0);

    // 12h hour rules.
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("h12Hl0Rejected", int'(aField[1]), 1);
    applyStimulus(1, 1, 0);
    checkOutput("h12Hl1Accepted", int'(aField[1]), 2);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(3, 1, 0);
    checkOutput("h12Hl3Rejected", int'(aField[1]), 1);
    applyStimulus(2, 1, 0);
    applyStimulus(4, 1, 0);
    applyStimulus(5, 1, 0);
    checkTime("commit12h", 1, 1245);
    checkTime("commit24hSameKeys", 0, 1324);
    applyStimulus(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
